// File: rtl/arm_pkg.sv
// Shared ARM-subset constants: ALU commands, opcodes, modes, condition codes,
// the decoded control bundle and the condition-check helper.
package arm_pkg;

  localparam int ARM_STATUS_W = 4;

  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  typedef struct packed {
    logic [3:0] exe_cmd;
    logic       mem_read;
    logic       mem_write;
    logic       wb_en;
    logic       b;
    logic       s;
  } ctrl_t;

  // status is {N,Z,C,V}
  function automatic logic cond_pass(input logic [3:0] cond,
                                     input logic [ARM_STATUS_W-1:0] status);
    logic n, z, c, v, r;
    {n, z, c, v} = status;
    case (cond)
      COND_EQ: r = z;
      COND_NE: r = ~z;
      COND_CS: r = c;
      COND_CC: r = ~c;
      COND_MI: r = n;
      COND_PL: r = ~n;
      COND_VS: r = v;
      COND_VC: r = ~v;
      COND_HI: r = c & ~z;
      COND_LS: r = ~c | z;
      COND_GE: r = (n == v);
      COND_LT: r = (n != v);
      COND_GT: r = ~z & (n == v);
      COND_LE: r = z | (n != v);
      COND_AL: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/regfile_mp.sv
// Register file, 2 combinational read ports / 1 write port, async active-low reset.
// ID_WB_BYPASS_EN forwards the same-cycle write-back value to matching reads.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int NREG   = 16,
  parameter int PC_REG = 15,
  localparam int RI    = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en,
  input  logic [RI-1:0]     wb_dest,
  input  logic [DATA_W-1:0] wb_value,
  input  logic [RI-1:0]     raddr1,
  input  logic [RI-1:0]     raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs [NREG];
  logic              wr_fire;

  // The PC index is virtual: it is served by the top and never stored.
  assign wr_fire = wb_en & (wb_dest != RI'(PC_REG));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_fire) begin
      regs[wb_dest] <= wb_value;
    end
  end

`ifdef ID_WB_BYPASS_EN
  assign rdata1 = (wr_fire && raddr1 == wb_dest) ? wb_value : regs[raddr1];
  assign rdata2 = (wr_fire && raddr2 == wb_dest) ? wb_value : regs[raddr2];
`else
  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];
`endif

endmodule

// File: rtl/id_stage_pipe.sv
// ARM-subset decode stage with register file, condition check and ID/EX register.
// Optional macro ID_WB_BYPASS_EN enables same-cycle write-back forwarding.
module id_stage_pipe
  import arm_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREG   = 16,
  parameter int PC_REG = 15,
  localparam int RI    = $clog2(NREG)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             instr_in,
  input  logic [DATA_W-1:0]       pc_in,
  input  logic [ARM_STATUS_W-1:0] status,
  input  logic                    wb_en,
  input  logic [RI-1:0]           wb_dest,
  input  logic [DATA_W-1:0]       wb_value,
  input  logic                    hazard,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       reg1_out,
  output logic [DATA_W-1:0]       reg2_out,
  output logic [DATA_W-1:0]       pc_out,
  output logic [3:0]              exe_cmd_out,
  output logic                    mem_read_out,
  output logic                    mem_write_out,
  output logic                    wb_en_out,
  output logic                    b_out,
  output logic                    s_out,
  output logic                    imm_out,
  output logic [11:0]             shift_op_out,
  output logic [23:0]             imm24_out,
  output logic [RI-1:0]           dest_out,
  output logic [RI-1:0]           haz_rn,
  output logic [RI-1:0]           haz_rdm,
  output logic                    haz_two_src
);

  function automatic ctrl_t decode(input logic [31:0] instr);
    ctrl_t c;
    c = '0;
    case (instr[27:26])
      MODE_DP: begin
        c.wb_en = 1'b1;
        c.s     = instr[20];
        case (instr[24:21])
          OP_MOV:  c.exe_cmd = EXE_MOV;
          OP_MVN:  c.exe_cmd = EXE_MVN;
          OP_ADD:  c.exe_cmd = EXE_ADD;
          OP_ADC:  c.exe_cmd = EXE_ADC;
          OP_SUB:  c.exe_cmd = EXE_SUB;
          OP_SBC:  c.exe_cmd = EXE_SBC;
          OP_AND:  c.exe_cmd = EXE_AND;
          OP_ORR:  c.exe_cmd = EXE_ORR;
          OP_EOR:  c.exe_cmd = EXE_EOR;
          OP_CMP:  begin c.exe_cmd = EXE_SUB; c.wb_en = 1'b0; c.s = 1'b1; end
          OP_TST:  begin c.exe_cmd = EXE_AND; c.wb_en = 1'b0; c.s = 1'b1; end
          default: c = '0;
        endcase
      end
      MODE_MEM: begin
        c.exe_cmd   = EXE_ADD;
        c.mem_read  = instr[20];
        c.wb_en     = instr[20];
        c.mem_write = ~instr[20];
      end
      MODE_BR: c.b = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  logic              is_str;
  logic [RI-1:0]     src1, src2;
  logic [DATA_W-1:0] rf_rd1, rf_rd2, rd1, rd2;
  ctrl_t             ctrl_dec, ctrl_eff;
  logic              accept;

  // A store reads Rd as its second source (the value to write to memory).
  assign is_str      = (instr_in[27:26] == MODE_MEM) & ~instr_in[20];
  assign src1        = RI'(instr_in[19:16]);
  assign src2        = is_str ? RI'(instr_in[15:12]) : RI'(instr_in[3:0]);
  assign haz_rn      = src1;
  assign haz_rdm     = src2;
  assign haz_two_src = ~instr_in[25] | is_str;

  regfile_mp #(.DATA_W(DATA_W), .NREG(NREG), .PC_REG(PC_REG)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .wb_en    (wb_en),
    .wb_dest  (wb_dest),
    .wb_value (wb_value),
    .raddr1   (src1),
    .raddr2   (src2),
    .rdata1   (rf_rd1),
    .rdata2   (rf_rd2)
  );

  assign rd1 = (src1 == RI'(PC_REG)) ? pc_in : rf_rd1;
  assign rd2 = (src2 == RI'(PC_REG)) ? pc_in : rf_rd2;

  assign ctrl_dec = decode(instr_in);
  assign ctrl_eff = cond_pass(instr_in[31:28], status) ? ctrl_dec : '0;

  assign in_ready = ~hazard & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready & ~flush;

  // Flush wins over everything; otherwise load, drain, or hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid     <= 1'b0;
      reg1_out      <= '0;
      reg2_out      <= '0;
      pc_out        <= '0;
      exe_cmd_out   <= '0;
      mem_read_out  <= 1'b0;
      mem_write_out <= 1'b0;
      wb_en_out     <= 1'b0;
      b_out         <= 1'b0;
      s_out         <= 1'b0;
      imm_out       <= 1'b0;
      shift_op_out  <= '0;
      imm24_out     <= '0;
      dest_out      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      reg1_out      <= rd1;
      reg2_out      <= rd2;
      pc_out        <= pc_in;
      exe_cmd_out   <= ctrl_eff.exe_cmd;
      mem_read_out  <= ctrl_eff.mem_read;
      mem_write_out <= ctrl_eff.mem_write;
      wb_en_out     <= ctrl_eff.wb_en;
      b_out         <= ctrl_eff.b;
      s_out         <= ctrl_eff.s;
      imm_out       <= instr_in[25];
      shift_op_out  <= instr_in[11:0];
      imm24_out     <= instr_in[23:0];
      dest_out      <= RI'(instr_in[15:12]);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
